mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: extra wait cycles in MEM state (legal range 0..7).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode  input  6  IR[31:26] of the current instruction.
REQ-005 SHALL have port funct  input  6  IR[5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag, valid in EXE.
REQ-007 SHALL have outputs PCWr, IRWr, RegWr, MemWr, IorD, ALUSrcA, each 1 bit.
REQ-008 SHALL have outputs ALUSrcB[1:0] (0 regB, 1 sign-ext imm, 2 zero-ext imm, 3 const 4) and PCSrc[1:0] (0 ALU, 1 branch target, 2 jump target).
REQ-009 SHALL have outputs RegDst[1:0] (0 rt, 1 rd, 2 $31) and MemToReg[1:0] (0 ALU, 1 mem, 2 PC).
REQ-010 SHALL have output ALUOp[2:0] (000 add, 001 sub, 010 and, 011 or, 100 slt).
REQ-011 SHALL have outputs state[2:0] (current state) and halted (1 bit).

Function
REQ-012 States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6/7 SHALL go to IF.
REQ-013 Supported: R-type op 000000 (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt), addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, halt 111111.
REQ-014 IF: PCWr=1, IRWr=1, IorD=0, ALUSrcA=0, ALUSrcB=3, ALUOp=add, PCSrc=0; next ID.
REQ-015 ID: j -> PCWr=1, PCSrc=2, next IF; halt -> HALT; unknown opcode or unknown R-type funct -> IF with no write (nop); all other instructions -> EXE.
REQ-016 EXE: ALUSrcA=1; R-type ALUSrcB=0 with ALUOp from funct; addi/lw/sw ALUSrcB=1, add; ori ALUSrcB=2, or.
REQ-017 EXE: beq/bne ALUSrcB=0, sub, PCSrc=1, PCWr=zero (beq) or ~zero (bne), sampled same cycle; next IF.
REQ-018 EXE: lw/sw -> MEM; R-type/addi/ori -> WB.
REQ-019 MEM: IorD=1; state held exactly MEM_WAIT+1 cycles by an internal wait counter; MemWr=1 for sw only in the final MEM cycle; then lw -> WB, sw -> IF.
REQ-020 WB: RegWr=1 for exactly one cycle; RegDst=1/MemToReg=0 for R-type, RegDst=0/MemToReg=0 for addi/ori, RegDst=0/MemToReg=1 for lw; next IF.
REQ-021 HALT: all write enables 0, halted=1; state held until reset.
REQ-022 Outputs SHALL be combinational from state, opcode, funct, zero, and wait counter; unlisted outputs are 0 in each state.
REQ-023 At most one of RegWr/MemWr/IRWr SHALL be high in any cycle.

Reset
REQ-024 rst=0 SHALL immediately force state=IF, wait counter=0, halted=0.
REQ-025 While rst=0, PCWr, IRWr, RegWr, and MemWr SHALL be 0, independent of state.
REQ-026 Reset asserted mid-MEM or mid-WB SHALL abort the write in the same cycle; the first IF follows the first rising edge after release.

Configuration
REQ-027 With macro MC_CTRL_JAL_EN defined, jal (000011) SHALL go ID -> WB; in WB it SHALL drive RegWr=1, RegDst=2, MemToReg=2, PCWr=1, PCSrc=2, then go to IF.
REQ-028 Without MC_CTRL_JAL_EN, jal SHALL be decoded as an unknown opcode (nop, ID -> IF).

Verification
REQ-029 add (op 0, funct 100000), MEM_WAIT=0 -> states 0,1,2,4,0; RegWr=1 only in state 4 with RegDst=1; ALUOp=000 in EXE.
REQ-030 lw with MEM_WAIT=2 -> 3 consecutive MEM cycles, MemWr=0 throughout, then WB with MemToReg=1, i.e. 7 cycles total; sw -> MemWr=1 only in 3rd MEM cycle, 6 cycles total.
REQ-031 beq with zero=1 -> PCWr=1, PCSrc=1 in EXE; bne with zero=1 -> PCWr=0; both return to IF after 3 cycles.
REQ-032 opcode 111111 -> HALT after ID, halted=1 for 20 further cycles; rst pulse low -> state=0, halted=0 immediately.
REQ-033 rst driven low during sw final MEM cycle -> MemWr drops to 0 within the same cycle; state=0.
REQ-034 jal with MC_CTRL_JAL_EN -> WB shows RegWr=1, RegDst=2, MemToReg=2, PCSrc=2; without the macro -> states 0,1,0 with no write.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control FSM: IF/ID/EXE/MEM/WB/HALT with combinational control outputs.
// Optional feature: define MC_CTRL_JAL_EN to decode jal (ID -> WB, link to $31, jump).
module mc_control_fsm #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [2:0] ALUOp,
    output logic [2:0] state,
    output logic       halted
);

    localparam int unsigned WAIT_W = 3;

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EXE  = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_SEXT = 2'd1;
    localparam logic [1:0] SRCB_ZEXT = 2'd2;
    localparam logic [1:0] SRCB_FOUR = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    logic [2:0]        stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;

    logic isR, isAddi, isOri, isLw, isSw, isBeq, isBne, isJ, isJal, isHalt;
    logic functOk;
    logic toExe;
    logic lastMem;
    logic [2:0] rAluOp;

    // Instruction decode
    assign isR    = (opcode == OP_RTYPE);
    assign isAddi = (opcode == OP_ADDI);
    assign isOri  = (opcode == OP_ORI);
    assign isLw   = (opcode == OP_LW);
    assign isSw   = (opcode == OP_SW);
    assign isBeq  = (opcode == OP_BEQ);
    assign isBne  = (opcode == OP_BNE);
    assign isJ    = (opcode == OP_J);
    assign isJal  = (opcode == OP_JAL);
    assign isHalt = (opcode == OP_HALT);

    always_comb begin
        functOk = 1'b1;
        rAluOp  = ALU_ADD;
        case (funct)
            6'b100000: rAluOp = ALU_ADD;
            6'b100010: rAluOp = ALU_SUB;
            6'b100100: rAluOp = ALU_AND;
            6'b100101: rAluOp = ALU_OR;
            6'b101010: rAluOp = ALU_SLT;
            default:   functOk = 1'b0;
        endcase
    end

    assign toExe   = (isR && functOk) || isAddi || isOri || isLw || isSw || isBeq || isBne;
    assign lastMem = (waitCnt == WAIT_W'(MEM_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IF;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // Next state and control outputs
    always_comb begin
        stateNext   = S_IF;
        waitCntNext = '0;
        PCWr        = 1'b0;
        IRWr        = 1'b0;
        RegWr       = 1'b0;
        MemWr       = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSrc       = PC_ALU;
        RegDst      = DST_RT;
        MemToReg    = M2R_ALU;
        ALUOp       = ALU_ADD;
        halted      = 1'b0;

        case (state)
            S_IF: begin
                PCWr      = 1'b1;
                IRWr      = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALU_ADD;
                stateNext = S_ID;
            end
            S_ID: begin
                if (isJ) begin
                    PCWr      = 1'b1;
                    PCSrc     = PC_JUMP;
                    stateNext = S_IF;
                end else if (isHalt) begin
                    stateNext = S_HALT;
`ifdef MC_CTRL_JAL_EN
                end else if (isJal) begin
                    stateNext = S_WB;
`endif
                end else if (toExe) begin
                    stateNext = S_EXE;
                end else begin
                    stateNext = S_IF;
                end
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                if (isR) begin
                    ALUSrcB   = SRCB_REG;
                    ALUOp     = rAluOp;
                    stateNext = S_WB;
                end else if (isAddi) begin
                    ALUSrcB   = SRCB_SEXT;
                    stateNext = S_WB;
                end else if (isOri) begin
                    ALUSrcB   = SRCB_ZEXT;
                    ALUOp     = ALU_OR;
                    stateNext = S_WB;
                end else if (isLw || isSw) begin
                    ALUSrcB   = SRCB_SEXT;
                    stateNext = S_MEM;
                end else if (isBeq || isBne) begin
                    ALUSrcB   = SRCB_REG;
                    ALUOp     = ALU_SUB;
                    PCSrc     = PC_BRANCH;
                    PCWr      = isBeq ? zero : ~zero;
                    stateNext = S_IF;
                end
            end
            S_MEM: begin
                IorD = 1'b1;
                if (lastMem) begin
                    MemWr     = isSw;
                    stateNext = isLw ? S_WB : S_IF;
                end else begin
                    waitCntNext = waitCnt + WAIT_W'(1);
                    stateNext   = S_MEM;
                end
            end
            S_WB: begin
                if (isR) begin
                    RegWr  = 1'b1;
                    RegDst = DST_RD;
                end else if (isAddi || isOri) begin
                    RegWr = 1'b1;
                end else if (isLw) begin
                    RegWr    = 1'b1;
                    MemToReg = M2R_MEM;
`ifdef MC_CTRL_JAL_EN
                end else if (isJal) begin
                    RegWr    = 1'b1;
                    RegDst   = DST_RA;
                    MemToReg = M2R_PC;
                    PCWr     = 1'b1;
                    PCSrc    = PC_JUMP;
`endif
                end
                stateNext = S_IF;
            end
            S_HALT: begin
                halted    = 1'b1;
                stateNext = S_HALT;
            end
            default: stateNext = S_IF;
        endcase

        // Reset kills every write in the same cycle, whatever state is showing
        if (!rst) begin
            PCWr  = 1'b0;
            IRWr  = 1'b0;
            RegWr = 1'b0;
            MemWr = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm (MEM_WAIT=2): directed instruction sequences, per-cycle expected outputs.
`timescale 1ns/1ps
module tb_mc_control_fsm;

    typedef struct packed {
        logic [2:0] st;
        logic       hl;
        logic       pcWr;
        logic       irWr;
        logic       regWr;
        logic       memWr;
        logic       iorD;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] pcSrc;
        logic [1:0] regDst;
        logic [1:0] m2r;
        logic [2:0] aluOp;
    } outs_t;

    typedef struct {
        outs_t v;
        string name;
    } exp_t;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    event chkEv;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       PCWr, IRWr, RegWr, MemWr, IorD, ALUSrcA, halted;
    logic [1:0] ALUSrcB, PCSrc, RegDst, MemToReg;
    logic [2:0] ALUOp, state;
    outs_t      act;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_WAIT(2)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .IorD(IorD),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .RegDst(RegDst),
        .MemToReg(MemToReg), .ALUOp(ALUOp), .state(state), .halted(halted)
    );

    assign act = {state, halted, PCWr, IRWr, RegWr, MemWr, IorD, ALUSrcA,
                  ALUSrcB, PCSrc, RegDst, MemToReg, ALUOp};

    function automatic outs_t mk(input int st, input int hl, input int pcw, input int irw,
                                 input int rgw, input int mw, input int iod, input int sa,
                                 input int sb, input int ps, input int rd, input int mr,
                                 input int op);
        outs_t o;
        o.st = 3'(st);    o.hl = 1'(hl);    o.pcWr = 1'(pcw); o.irWr = 1'(irw);
        o.regWr = 1'(rgw); o.memWr = 1'(mw); o.iorD = 1'(iod); o.srcA = 1'(sa);
        o.srcB = 2'(sb);  o.pcSrc = 2'(ps); o.regDst = 2'(rd); o.m2r = 2'(mr);
        o.aluOp = 3'(op);
        return o;
    endfunction

    outs_t eIF, eID, eRst, eMem, eHalt;

    task automatic push(input outs_t v, input string nm);
        exp_t e;
        e.v = v;
        e.name = nm;
        expQ.push_back(e);
    endtask

    task automatic step(input outs_t v, input string nm);
        push(v, nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT outputs against the oldest expectation
    exp_t mon;
    initial begin
        forever begin
            @(negedge clk or chkEv);
            if (expQ.size() > 0) begin
                mon = expQ.pop_front();
                nCompared++;
                if (act !== mon.v) begin
                    nMismatched++;
                    $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                             mon.name, act, mon.v, act.st, mon.v.st);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [5:0] fTab[5];
    logic [2:0] aTab[5];
    logic [5:0] bOp[4];
    logic       bZero[4];
    int         bPcw[4];

    initial begin
        eIF   = mk(0,0,1,1,0,0,0,0,3,0,0,0,0);
        eID   = mk(1,0,0,0,0,0,0,0,0,0,0,0,0);
        eRst  = mk(0,0,0,0,0,0,0,0,3,0,0,0,0);
        eMem  = mk(3,0,0,0,0,0,1,0,0,0,0,0,0);
        eHalt = mk(5,1,0,0,0,0,0,0,0,0,0,0,0);
        fTab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        aTab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        bOp   = '{6'h04, 6'h05, 6'h04, 6'h05};
        bZero = '{1'b1, 1'b1, 1'b0, 1'b0};
        bPcw  = '{1, 0, 0, 1};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(eRst, "reset_state");
        rst = 1'b1;

        // R-type: add, sub, and, or, slt
        for (int i = 0; i < 5; i++) begin
            opcode = 6'h00;
            funct  = fTab[i];
            step(eIF, "r_if");
            step(eID, "r_id");
            step(mk(2,0,0,0,0,0,0,1,0,0,0,0,int'(aTab[i])), "r_exe");
            step(mk(4,0,0,0,1,0,0,0,0,0,1,0,0), "r_wb");
        end

        opcode = 6'h08; funct = 6'h00;
        step(eIF, "addi_if");
        step(eID, "addi_id");
        step(mk(2,0,0,0,0,0,0,1,1,0,0,0,0), "addi_exe");
        step(mk(4,0,0,0,1,0,0,0,0,0,0,0,0), "addi_wb");

        opcode = 6'h0D;
        step(eIF, "ori_if");
        step(eID, "ori_id");
        step(mk(2,0,0,0,0,0,0,1,2,0,0,0,3), "ori_exe");
        step(mk(4,0,0,0,1,0,0,0,0,0,0,0,0), "ori_wb");

        opcode = 6'h23;
        step(eIF, "lw_if");
        step(eID, "lw_id");
        step(mk(2,0,0,0,0,0,0,1,1,0,0,0,0), "lw_exe");
        step(eMem, "lw_mem1");
        step(eMem, "lw_mem2");
        step(eMem, "lw_mem3");
        step(mk(4,0,0,0,1,0,0,0,0,0,0,1,0), "lw_wb");

        opcode = 6'h2B;
        step(eIF, "sw_if");
        step(eID, "sw_id");
        step(mk(2,0,0,0,0,0,0,1,1,0,0,0,0), "sw_exe");
        step(eMem, "sw_mem1");
        step(eMem, "sw_mem2");
        step(mk(3,0,0,0,0,1,1,0,0,0,0,0,0), "sw_mem3_write");

        for (int i = 0; i < 4; i++) begin
            opcode = bOp[i];
            zero   = bZero[i];
            step(eIF, "br_if");
            step(eID, "br_id");
            step(mk(2,0,bPcw[i],0,0,0,0,1,0,1,0,0,1), "br_exe");
        end
        zero = 1'b0;

        opcode = 6'h02;
        step(eIF, "j_if");
        step(mk(1,0,1,0,0,0,0,0,0,2,0,0,0), "j_id");

        opcode = 6'h3E;
        step(eIF, "badop_if");
        step(eID, "badop_id");

        opcode = 6'h00; funct = 6'h00;
        step(eIF, "badfunct_if");
        step(eID, "badfunct_id");

        opcode = 6'h03;
        step(eIF, "jal_if");
        step(eID, "jal_id");
`ifdef MC_CTRL_JAL_EN
        step(mk(4,0,1,0,1,0,0,0,0,2,2,2,0), "jal_wb");
`endif

        // Reset dropped inside the final sw MEM cycle
        opcode = 6'h2B;
        step(eIF, "swr_if");
        step(eID, "swr_id");
        step(mk(2,0,0,0,0,0,0,1,1,0,0,0,0), "swr_exe");
        step(eMem, "swr_mem1");
        step(eMem, "swr_mem2");
        push(mk(3,0,0,0,0,1,1,0,0,0,0,0,0), "swr_mem3_write");
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        push(eRst, "swr_abort_same_cycle");
        ->chkEv;
        #1;
        @(posedge clk);
        #1;
        step(eRst, "swr_held_in_reset");
        rst = 1'b1;

        opcode = 6'h3F;
        step(eIF, "halt_if");
        step(eID, "halt_id");
        for (int i = 0; i < 20; i++) step(eHalt, "halt_hold");
        rst = 1'b0;
        step(eRst, "halt_reset_immediate");
        rst = 1'b1;
        opcode = 6'h3E;
        step(eIF, "post_reset_if");
        step(eID, "post_reset_id");
        step(eIF, "post_reset_if2");

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
